dmem_lsu: RTL



---
 rtl/dmem_lsu.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit with integrated word-organised data memory.
// Combinational loads, edge-committed stores, and a sticky first-fault status record.
module dmem_lsu #(
    parameter int unsigned n     = 32,
    parameter int unsigned DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    output logic [n-1:0] rdata,
    output logic         fault,
    output logic         fault_sticky,
    output logic [n-1:0] fault_addr,
    output logic [1:0]   fault_cause
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [31:0]   word;
    logic [31:0]   shifted;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic          access;
    logic          legal_f3;
    logic          illegal_op;
    logic          misaligned;
    logic          out_of_range;
    logic [1:0]    cause;
    logic [3:0]    be;
    logic [31:0]   wlanes;

    assign access   = mem_read | mem_write;
    assign word_idx = addr[AW+1:2];
    assign word     = mem[word_idx];

    always_comb begin
        legal_f3     = (funct3 == F3B) || (funct3 == F3H) || (funct3 == F3W) ||
                       (funct3 == F3BU) || (funct3 == F3HU);
        illegal_op   = !legal_f3 || (mem_write && funct3[2]) || (mem_read && mem_write);
        misaligned   = ((funct3 == F3H || funct3 == F3HU) && addr[0]) ||
                       ((funct3 == F3W) && (addr[1:0] != 2'b00));
        out_of_range = (addr[n-1:AW+2] != '0);
        cause        = 2'b00;
        if (illegal_op) begin
            cause = 2'b11;
        end else if (misaligned) begin
            cause = 2'b01;
        end else if (out_of_range) begin
            cause = 2'b10;
        end
        fault = access && (cause != 2'b00);
    end

    // Loads see the pre-edge contents, so a same-cycle store is not forwarded.
    always_comb begin
        shifted = word >> {addr[1:0], 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = addr[1] ? word[31:16] : word[15:0];
        rdata   = '0;
        if (mem_read && !fault) begin
            case (funct3)
                F3B:     rdata = n'($signed(lane_b));
                F3H:     rdata = n'($signed(lane_h));
                F3W:     rdata = n'(word);
                F3BU:    rdata = n'(lane_b);
                F3HU:    rdata = n'(lane_h);
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        be     = 4'b0000;
        wlanes = wdata[31:0];
        case (funct3)
            F3B: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            F3H: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            F3W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (!mem_write || fault) begin
            be = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    // Only the first fault after reset is recorded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_sticky <= 1'b0;
            fault_addr   <= '0;
            fault_cause  <= 2'b00;
        end else if (fault && !fault_sticky) begin
            fault_sticky <= 1'b1;
            fault_addr   <= addr;
            fault_cause  <= cause;
        end
    end

endmodule
